prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Writer side of the program ROM: takes a byte stream (length, payload, checksum)
//   over a valid/ready handshake and writes it into program memory, which the CPU
//   fetch path reads two bytes per instruction (opcode1 = mem[PC], opcode2 = mem[PC+1]).
//   Holds the CPU in reset while loading and releases it only after the checksum passes.
// PARAMETERS
//   START_ADDR  8'h00  first program-memory address written
//   TIMEOUT     1023   max idle cycles between accepted bytes while loading (>=1)
// PORTS
//   clk           in   1  clock, rising edge
//   PC_reset      in   1  reset, asynchronous, active-high
//   start         in   1  1-cycle request to begin a load
//   in_valid      in   1  in_data valid
//   in_data       in   8  stream byte
//   in_ready      out  1  loader accepts in_data this cycle
//   pm_we         out  1  program-memory write strobe, 1-cycle pulse
//   pm_addr       out  8  program-memory write address
//   pm_wdata      out  8  program-memory write data
//   cpu_hold      out  1  1 = keep CPU PC in reset
//   busy          out  1  1 in LEN/DATA/CSUM
//   done          out  1  sticky: last load passed checksum
//   chk_err       out  1  sticky: last load failed checksum
//   tmo_err       out  1  sticky: last load timed out
//   bytes_loaded  out  9  payload bytes written in current/last load (0..256)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; sum, count, timer cleared. Async, takes
//     effect mid-load; a partially written image is not undone.
//   Accept = in_valid & in_ready. in_ready = busy (combinational from state).
//   States: IDLE, LEN, DATA, CSUM, DONE, ERR.
//   IDLE/DONE/ERR + start -> LEN next cycle; clears done/chk_err/tmo_err,
//     sum, bytes_loaded, timer; sets cpu_hold=1. start in LEN/DATA/CSUM ignored.
//   LEN: accepted byte L -> remaining = (L==0) ? 256 : L; -> DATA.
//   DATA: each accepted byte b: next cycle pm_we=1, pm_addr=START_ADDR+idx
//     (8-bit, wraps 8'hFF->8'h00), pm_wdata=b; sum=(sum+b) mod 256;
//     bytes_loaded++. Acceptance of the remaining==1 byte -> CSUM.
//     Back-to-back accepts give back-to-back pm_we pulses; pm_addr/pm_wdata
//     hold last values when pm_we=0.
//   CSUM: accepted byte c; c==sum -> DONE (done=1, cpu_hold=0);
//     else -> ERR (chk_err=1, cpu_hold stays 1).
//   Timeout: timer counts cycles in LEN/DATA/CSUM without an accept, clears on
//     accept; reaching TIMEOUT -> ERR, tmo_err=1, cpu_hold stays 1. Accept in
//     the same cycle the timer would expire wins (no timeout).
//   Latency: pm_write 1 cycle after accept; done/chk_err and cpu_hold change
//     1 cycle after checksum accept.
//   DONE/ERR flags persist until next start or reset.
// TESTING
//   Reset, start; stream 03,AA,BB,CC,31 -> pm writes 00:AA,01:BB,02:CC; done=1,
//     cpu_hold 1->0, bytes_loaded=3.
//   Same stream, checksum 30 -> chk_err=1, done=0, cpu_hold=1.
//   Len 00, 256 bytes of 01, checksum 00 -> 256 writes, addr 00..FF, done=1,
//     bytes_loaded=256; START_ADDR=8'hF0 -> addr wraps FF->00 at byte 16.
//   in_valid toggled randomly -> writes only on accepts, no gaps/duplicates.
//   TIMEOUT=8, stall 8 cycles after 2nd payload byte -> tmo_err=1, state ERR,
//     in_ready=0; start during load ignored; start in ERR restarts cleanly.
//   PC_reset asserted mid-DATA -> all outputs 0 same cycle, IDLE, next start OK.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writer side of the program ROM. Receives a framed byte stream
//   (length, payload, checksum) over a valid/ready handshake and writes the
//   payload into program memory starting at START_ADDR. The CPU is held in
//   reset while an image is being loaded. It is released only when the
//   checksum matches.
//
// Parameters
//   START_ADDR   first program-memory address written (8-bit, wraps)
//   TIMEOUT      idle cycles allowed between accepted bytes while loading
//
// Ports
//   clk          in   clock, rising edge
//   PC_reset     in   asynchronous, active-high reset
//   start        in   1-cycle request to begin a load (ignored while busy)
//   in_valid     in   in_data is valid
//   in_data      in   stream byte
//   in_ready     out  loader accepts in_data this cycle (equals busy)
//   pm_we        out  program-memory write strobe, 1-cycle pulse
//   pm_addr      out  program-memory write address
//   pm_wdata     out  program-memory write data
//   cpu_hold     out  1 = keep the CPU PC in reset
//   busy         out  1 while in LEN / DATA / CSUM
//   done         out  sticky: last load passed its checksum
//   chk_err      out  sticky: last load failed its checksum
//   tmo_err      out  sticky: last load timed out
//   bytes_loaded out  payload bytes written in the current/last load (0..256)
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter int         TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       PC_reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       pm_we,
  output logic [7:0] pm_addr,
  output logic [7:0] pm_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       chk_err,
  output logic       tmo_err,
  output logic [8:0] bytes_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  // The timer holds the number of idle cycles already seen. The idle cycle
  // that finds it at TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [7:0]    r_sum;
  logic [8:0]    r_remaining;
  logic [8:0]    r_bytes_loaded;
  logic [TW-1:0] r_timer;
  logic          r_pm_we;
  logic [7:0]    r_pm_addr;
  logic [7:0]    r_pm_wdata;
  logic          r_cpu_hold;
  logic          r_done;
  logic          r_chk_err;
  logic          r_tmo_err;

  logic          w_busy;
  logic          w_accept;

  assign w_busy   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept = in_valid && w_busy;

  // NOTE: every register in this block uses non-blocking assignment. All
  // registers then see pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge PC_reset) begin
    if (PC_reset) begin
      r_state        <= S_IDLE;
      r_sum          <= '0;
      r_remaining    <= '0;
      r_bytes_loaded <= '0;
      r_timer        <= '0;
      r_pm_we        <= 1'b0;
      r_pm_addr      <= '0;
      r_pm_wdata     <= '0;
      r_cpu_hold     <= 1'b0;
      r_done         <= 1'b0;
      r_chk_err      <= 1'b0;
      r_tmo_err      <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low every cycle, so it can only ever be a
      // single-cycle pulse. Address and data keep their last values.
      r_pm_we <= 1'b0;

      if (w_busy) begin
        if (w_accept) begin
          r_timer <= '0;
          unique case (r_state)
            S_LEN: begin
              // A length byte of zero encodes a full 256-byte image.
              r_remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
              r_state     <= S_DATA;
            end
            S_DATA: begin
              r_pm_we        <= 1'b1;
              r_pm_addr      <= START_ADDR + r_bytes_loaded[7:0];
              r_pm_wdata     <= in_data;
              r_sum          <= r_sum + in_data;
              r_bytes_loaded <= r_bytes_loaded + 9'd1;
              r_remaining    <= r_remaining - 9'd1;
              if (r_remaining == 9'd1) r_state <= S_CSUM;
            end
            S_CSUM: begin
              if (in_data == r_sum) begin
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end else begin
                r_state   <= S_ERR;
                r_chk_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (r_timer == TMO_LAST) begin
          r_state   <= S_ERR;
          r_tmo_err <= 1'b1;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end else if (start) begin
        r_state        <= S_LEN;
        r_done         <= 1'b0;
        r_chk_err      <= 1'b0;
        r_tmo_err      <= 1'b0;
        r_sum          <= '0;
        r_bytes_loaded <= '0;
        r_timer        <= '0;
        r_cpu_hold     <= 1'b1;
      end
    end
  end

  assign in_ready     = w_busy;
  assign busy         = w_busy;
  assign pm_we        = r_pm_we;
  assign pm_addr      = r_pm_addr;
  assign pm_wdata     = r_pm_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign chk_err      = r_chk_err;
  assign tmo_err      = r_tmo_err;
  assign bytes_loaded = r_bytes_loaded;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Drives two loaders with identical stimulus. One is based at 8'h00 and the
//   other at 8'hF0, so that address wrap is exercised. Both use TIMEOUT = 8.
//   Expected writes and final flags come from the framing rules: the write
//   address is base + index, and the load passes when the 8-bit payload sum
//   equals the checksum byte.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int         TMO     = 8;
  localparam logic [7:0] START_B = 8'hF0;

  logic       clk = 1'b0;
  logic       PC_reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic [1:0] in_ready, pm_we, cpu_hold, busy, done, chk_err, tmo_err;
  logic [7:0] pm_addr      [2];
  logic [7:0] pm_wdata     [2];
  logic [8:0] bytes_loaded [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_data [$];
  int         wr_idx   [2] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    prog_loader #(
      .START_ADDR ((g == 0) ? 8'h00 : START_B),
      .TIMEOUT    (TMO)
    ) dut (
      .clk          (clk),
      .PC_reset     (PC_reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready[g]),
      .pm_we        (pm_we[g]),
      .pm_addr      (pm_addr[g]),
      .pm_wdata     (pm_wdata[g]),
      .cpu_hold     (cpu_hold[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .chk_err      (chk_err[g]),
      .tmo_err      (tmo_err[g]),
      .bytes_loaded (bytes_loaded[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] base_of(input int d);
    return (d == 0) ? 8'h00 : START_B;
  endfunction

  // Write monitor: every strobe must be the next expected payload byte at
  // base + index. Extra strobes show up as an index past the image.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pm_we[d] === 1'b1) begin
        if (wr_idx[d] < exp_data.size()) begin
          check($sformatf("wr_addr[%0d]#%0d", d, wr_idx[d]), 32'(pm_addr[d]),
                32'(8'(base_of(d) + 8'(wr_idx[d]))));
          check($sformatf("wr_data[%0d]#%0d", d, wr_idx[d]), 32'(pm_wdata[d]),
                32'(exp_data[wr_idx[d]]));
        end else begin
          check($sformatf("wr_extra[%0d]", d), 32'(wr_idx[d]), 32'(exp_data.size()));
        end
        wr_idx[d]++;
      end
    end
  end

  task automatic check_status(input string tag, input logic e_busy, input logic e_hold,
                              input logic e_done, input logic e_chk, input logic e_tmo,
                              input int e_bytes);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.in_ready[%0d]", tag, d), 32'(in_ready[d]), 32'(e_busy));
      check($sformatf("%s.busy[%0d]", tag, d),     32'(busy[d]),     32'(e_busy));
      check($sformatf("%s.cpu_hold[%0d]", tag, d), 32'(cpu_hold[d]), 32'(e_hold));
      check($sformatf("%s.done[%0d]", tag, d),     32'(done[d]),     32'(e_done));
      check($sformatf("%s.chk_err[%0d]", tag, d),  32'(chk_err[d]),  32'(e_chk));
      check($sformatf("%s.tmo_err[%0d]", tag, d),  32'(tmo_err[d]),  32'(e_tmo));
      check($sformatf("%s.bytes[%0d]", tag, d),    32'(bytes_loaded[d]), 32'(e_bytes));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.pm_we[%0d]", tag, d),    32'(pm_we[d]),    32'(0));
      check($sformatf("%s.pm_addr[%0d]", tag, d),  32'(pm_addr[d]),  32'(0));
      check($sformatf("%s.pm_wdata[%0d]", tag, d), 32'(pm_wdata[d]), 32'(0));
    end
  endtask

  // Called at a negedge. Leaves in_valid high so that consecutive calls
  // produce back-to-back accepts. Returns at the negedge after the accept.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full framed load of exp_data. csum_delta = 0 gives a correct checksum.
  task automatic run_load(input string tag, input logic [7:0] csum_delta, input int max_gap);
    logic [7:0] sum;
    logic [7:0] csum;
    int         n;
    logic       good;
    n    = exp_data.size();
    sum  = 8'h00;
    foreach (exp_data[i]) sum = sum + exp_data[i];
    csum = sum + csum_delta;
    good = (csum_delta == 8'h00);
    wr_idx = '{0, 0};
    pulse_start();
    check_status({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_byte(8'(n), $urandom_range(0, max_gap));
    foreach (exp_data[i]) send_byte(exp_data[i], $urandom_range(0, max_gap));
    check_status({tag, ".pre_csum"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, n);
    send_byte(csum, $urandom_range(0, max_gap));
    in_valid = 1'b0;
    check_status({tag, ".end"}, 1'b0, !good, good, !good, 1'b0, n);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s.nwrites[%0d]", tag, d), 32'(wr_idx[d]), 32'(n));
  endtask

  task automatic random_image(input int n);
    exp_data.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(8'($urandom));
  endtask

  initial begin
    PC_reset = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    PC_reset = 1'b0;
    @(negedge clk);

    // Directed stream with a good checksum (AA+BB+CC = 0x231, so 0x31 passes),
    // then the same stream with checksum 0x30.
    exp_data = '{8'hAA, 8'hBB, 8'hCC};
    run_load("basic_ok", 8'h00, 0);
    run_load("basic_bad", 8'hFF, 0);

    // Full 256-byte image of 0x01: the checksum is 0x00 and the F0 loader wraps.
    exp_data.delete();
    for (int i = 0; i < 256; i++) exp_data.push_back(8'h01);
    run_load("full256", 8'h00, 1);

    // Random images with random valid gaps of up to TMO-1 idle cycles. The
    // maximum gap lands the accept in the cycle the timer would expire.
    for (int k = 0; k < 12; k++) begin
      random_image($urandom_range(1, 24));
      run_load($sformatf("rand%0d", k),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, TMO - 1);
    end

    // Timeout: stall after the 2nd payload byte. A start pulse during the
    // stall must be ignored and must not reset the timer.
    random_image(5);
    wr_idx = '{0, 0};
    pulse_start();
    send_byte(8'd5, 0);
    send_byte(exp_data[0], 1);
    send_byte(exp_data[1], 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    check_status("tmo_edge", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    @(negedge clk);
    check_status("tmo", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    for (int d = 0; d < 2; d++)
      check($sformatf("tmo.nwrites[%0d]", d), 32'(wr_idx[d]), 32'(2));

    // A start issued in ERR restarts cleanly.
    random_image(7);
    run_load("after_err", 8'h00, 3);

    // Asynchronous reset in the middle of DATA.
    random_image(10);
    wr_idx = '{0, 0};
    pulse_start();
    send_byte(8'd10, 0);
    for (int i = 0; i < 4; i++) send_byte(exp_data[i], 0);
    in_valid = 1'b0;
    #1 PC_reset = 1'b1;
    #1 check_all_zero("rst_async");
    #1 PC_reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst_idle");

    random_image(9);
    run_load("after_rst", 8'h00, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
